// File: rtl/mips_pkg.sv
// mips_pkg: constants shared across the MIPS single-cycle core.
//   - MDOp encodings for the multiply/divide unit (MD_MULT..MD_MTLO)
//   - State encoding for the multiply/divide sequencer
//   - ALU control encodings used by the combinational ALU
package mips_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Signed variants get magnitude conversion on entry and a sign fix at the end.
  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// md_iter_core: one-bit-per-cycle datapath for unsigned shift-add multiply and
// restoring divide.
//   clk, rst   clock, asynchronous active-high reset
//   load       capture a_in (multiplier / dividend) and b_in (multiplicand / divisor)
//   step       perform one iteration; is_div selects divide vs multiply
//   acc        upper word: product high half / remainder
//   quo        lower word: product low half / quotient
//   last       counter has reached its final iteration
module md_iter_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] quo,
  output logic             last
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   sum, rem_sh, diff;

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh = {hi_q, lo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, opnd_q};
    if (load) begin
      hi_d   = '0;
      lo_d   = a_in;
      opnd_d = b_in;
      cnt_d  = CW'(WIDTH - 1);
    end else if (step) begin
      cnt_d = cnt_q - CW'(1);
      if (is_div) begin
        // Restoring step: keep the trial subtraction only if it did not borrow.
        if (!diff[WIDTH]) begin
          hi_d = diff[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = rem_sh[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        // Carry out of the add shifts into the top of the product.
        {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
    end
  end

  assign acc  = hi_q;
  assign quo  = lo_q;
  assign last = (cnt_q == '0);

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit with HI/LO registers.
//   clk, reset  clock, asynchronous active-high reset
//   start       request, sampled only while busy=0
//   MDOp        MULT/MULTU/DIV/DIVU/MTHI/MTLO (other codes do nothing)
//   A, B        rs / rt operands, latched at acceptance
//   busy        iterative operation in progress (CALC and FIX)
//   done        one-cycle pulse when new HI/LO become visible
//   div_zero    last DIV/DIVU had B==0; cleared by the next accepted op
//   HI, LO      result registers
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  md_state_e          state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               res_neg_q, res_neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               b_zero_q, b_zero_d;
  logic               busy_q, busy_d, done_q, done_d, dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic               core_load, core_step, core_last, in_signed;
  logic [WIDTH-1:0]   a_mag, b_mag, core_acc, core_quo;
  logic [2*WIDTH-1:0] product;

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (reset),
    .load   (core_load),
    .step   (core_step),
    .is_div (op_q[1]),
    .a_in   (a_mag),
    .b_in   (b_mag),
    .acc    (core_acc),
    .quo    (core_quo),
    .last   (core_last)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    b_zero_d  = b_zero_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    core_load = 1'b0;
    core_step = 1'b0;
    product   = {core_acc, core_quo};
    in_signed = md_is_signed(MDOp);
    a_mag     = (in_signed && A[WIDTH-1]) ? -A : A;
    b_mag     = (in_signed && B[WIDTH-1]) ? -B : B;

    case (state_q)
      MD_IDLE: begin
        if (start) begin
          case (MDOp)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              state_d   = MD_CALC;
              busy_d    = 1'b1;
              op_d      = MDOp;
              a_d       = A;
              res_neg_d = in_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
              rem_neg_d = in_signed && A[WIDTH-1];
              b_zero_d  = (B == '0);
              dz_d      = 1'b0;
              core_load = 1'b1;
            end
            MD_MTHI: begin
              hi_d = A;
              dz_d = 1'b0;
            end
            MD_MTLO: begin
              lo_d = A;
              dz_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
      MD_CALC: begin
        core_step = 1'b1;
        if (core_last) state_d = MD_FIX;
      end
      MD_FIX: begin
        state_d = MD_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (op_q[1]) begin
          if (b_zero_q) begin
            // Divide by zero reports the raw dividend, bypassing the sign fix.
            hi_d = a_q;
            lo_d = '1;
            dz_d = 1'b1;
          end else begin
            lo_d = res_neg_q ? -core_quo : core_quo;
            hi_d = rem_neg_q ? -core_acc : core_acc;
          end
        end else begin
          if (res_neg_q) product = -product;
          {hi_d, lo_d} = product;
        end
      end
      default: begin
        state_d = MD_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= MD_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      b_zero_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      b_zero_q  <= b_zero_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit. Expected HI/LO/div_zero come from a
// plain-arithmetic reference model (64-bit products, native / and %).
module tb_mult_div_unit;
  logic        clk, reset, start;
  logic [2:0]  MDOp;
  logic [31:0] A, B;
  logic        busy, done, div_zero;
  logic [31:0] HI, LO;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_hi, exp_lo;
  logic        exp_dz;

  localparam int LAT = 33;   // edges from the accepting edge to the done sample

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .MDOp(MDOp), .A(A), .B(B),
    .busy(busy), .done(done), .div_zero(div_zero), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, p;
    logic [63:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'b000: begin p = sa * sb; t = p; exp_hi = t[63:32]; exp_lo = t[31:0]; exp_dz = 1'b0; end
      3'b001: begin t = {32'b0, a} * {32'b0, b}; exp_hi = t[63:32]; exp_lo = t[31:0]; exp_dz = 1'b0; end
      3'b010, 3'b011: begin
        if (b == 32'd0) begin
          exp_lo = 32'hFFFF_FFFF; exp_hi = a; exp_dz = 1'b1;
        end else if (op == 3'b010) begin
          p = sa / sb; t = p; exp_lo = t[31:0];
          p = sa % sb; t = p; exp_hi = t[31:0];
          exp_dz = 1'b0;
        end else begin
          exp_lo = a / b; exp_hi = a % b; exp_dz = 1'b0;
        end
      end
      3'b100: begin exp_hi = a; exp_dz = 1'b0; end
      3'b101: begin exp_lo = a; exp_dz = 1'b0; end
      default: ;
    endcase
  endfunction

  // Polls (already 1 time unit past an edge) until done, bounded; lat=-1 on timeout.
  task automatic wait_done(input int n0, output int lat, output int busy_cyc);
    lat = -1;
    busy_cyc = 0;
    for (int n = n0; n < n0 + 80; n++) begin
      if (done === 1'b1) begin lat = n; break; end
      if (busy === 1'b1) busy_cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; MDOp = op; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; MDOp = 3'b111; A = $urandom; B = $urandom;
    model_apply(op, a, b);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cyc);
    issue(op, a, b);
    lat = 0;
    busy_cyc = 0;
    if (op <= 3'b011) wait_done(0, lat, busy_cyc);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      failures++;
      $display("FAIL reset_state got busy=%b done=%b dz=%b HI=%h LO=%h exp all zero", busy, done, div_zero, HI, LO);
    end
  endtask

  task automatic test_multu_timing();
    int lat, bc;
    run_op(3'b001, 32'hFFFF_FFFF, 32'd2, lat, bc);
    checks++;
    if (lat !== LAT) begin failures++; $display("FAIL multu_latency got=%0d exp=%0d", lat, LAT); end
    checks++;
    if (bc !== 33) begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=33", bc); end
    checks++;
    if (HI !== 32'h1 || LO !== 32'hFFFF_FFFE) begin
      failures++; $display("FAIL multu_result got=%h_%h exp=00000001_fffffffe", HI, LO);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL busy_in_done_cycle got=%b exp=0", busy); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL done_pulse_width got=%b exp=0", done); end
  endtask

  task automatic test_signed_directed();
    int lat, bc;
    run_op(3'b000, 32'hFFFF_FFFD, 32'd7, lat, bc);
    checks++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFEB) begin
      failures++; $display("FAIL mult_neg got=%h_%h exp=ffffffff_ffffffeb", HI, LO);
    end
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, lat, bc);
    checks++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
      failures++; $display("FAIL div_neg got HI=%h LO=%h exp HI=ffffffff LO=fffffffd", HI, LO);
    end
    run_op(3'b011, 32'd7, 32'd2, lat, bc);
    checks++;
    if (HI !== 32'd1 || LO !== 32'd3) begin
      failures++; $display("FAIL divu_small got HI=%h LO=%h exp HI=1 LO=3", HI, LO);
    end
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
    checks++;
    if (HI !== 32'd0 || LO !== 32'h8000_0000 || div_zero !== 1'b0) begin
      failures++; $display("FAIL div_overflow got HI=%h LO=%h dz=%b exp HI=0 LO=80000000 dz=0", HI, LO, div_zero);
    end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    run_op(3'b011, 32'h1234, 32'd0, lat, bc);
    checks++;
    if (lat !== LAT) begin failures++; $display("FAIL divzero_latency got=%0d exp=%0d", lat, LAT); end
    checks++;
    if (HI !== 32'h1234 || LO !== 32'hFFFF_FFFF || div_zero !== 1'b1) begin
      failures++; $display("FAIL divu_zero got HI=%h LO=%h dz=%b exp HI=1234 LO=ffffffff dz=1", HI, LO, div_zero);
    end
    run_op(3'b010, 32'hFFFF_FFFB, 32'd0, lat, bc);
    checks++;
    if (HI !== 32'hFFFF_FFFB || LO !== 32'hFFFF_FFFF || div_zero !== 1'b1) begin
      failures++; $display("FAIL div_zero_signed got HI=%h LO=%h dz=%b exp HI=fffffffb LO=ffffffff dz=1", HI, LO, div_zero);
    end
    run_op(3'b101, 32'hCAFE_0001, 32'd0, lat, bc);
    checks++;
    if (LO !== 32'hCAFE_0001 || HI !== 32'hFFFF_FFFB || div_zero !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL mtlo_clears_dz got HI=%h LO=%h dz=%b busy=%b exp HI=fffffffb LO=cafe0001 dz=0 busy=0", HI, LO, div_zero, busy);
    end
  endtask

  task automatic test_random();
    int lat, bc;
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      run_op(op, a, b, lat, bc);
      if (op <= 3'b011) begin
        checks++;
        if (lat !== LAT) begin failures++; $display("FAIL rand_latency op=%0d got=%0d exp=%0d", op, lat, LAT); end
      end
      checks++;
      if (HI !== exp_hi || LO !== exp_lo || div_zero !== exp_dz) begin
        failures++;
        $display("FAIL rand_result op=%0d a=%h b=%h got HI=%h LO=%h dz=%b exp HI=%h LO=%h dz=%b",
                 op, a, b, HI, LO, div_zero, exp_hi, exp_lo, exp_dz);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic [31:0] old_hi;
    old_hi = HI;
    issue(3'b001, 32'h0001_0000, 32'h0001_0003);
    repeat (4) begin @(posedge clk); #1; end
    // start+MTHI while busy must be ignored
    @(negedge clk); start = 1'b1; MDOp = 3'b100; A = 32'hDEAD_BEEF;
    @(posedge clk); #1; start = 1'b0; MDOp = 3'b111;
    checks++;
    if (HI !== old_hi || busy !== 1'b1) begin
      failures++; $display("FAIL start_while_busy got HI=%h busy=%b exp HI=%h busy=1", HI, busy, old_hi);
    end
    wait_done(5, lat, bc);
    checks++;
    if (lat !== LAT || HI !== exp_hi || LO !== exp_lo) begin
      failures++; $display("FAIL busy_ignore_result got lat=%0d HI=%h LO=%h exp lat=%0d HI=%h LO=%h", lat, HI, LO, LAT, exp_hi, exp_lo);
    end
    // start presented during the done cycle
    issue(3'b011, 32'd100, 32'd7);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got busy=%b exp=1", busy); end
    wait_done(0, lat, bc);
    checks++;
    if (lat !== LAT || HI !== 32'd2 || LO !== 32'd14) begin
      failures++; $display("FAIL b2b_result got lat=%0d HI=%h LO=%h exp lat=%0d HI=2 LO=e", lat, HI, LO, LAT);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    logic saw_done;
    issue(3'b010, 32'd1000, 32'd3);
    repeat (9) begin @(posedge clk); #1; end
    @(negedge clk); reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || done !== 1'b0) begin
      failures++; $display("FAIL reset_mid_op got busy=%b HI=%h LO=%h done=%b exp all zero", busy, HI, LO, done);
    end
    @(posedge clk); #1;
    @(negedge clk); reset = 1'b0;
    exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1) saw_done = 1'b1; end
    checks++;
    if (saw_done !== 1'b0) begin failures++; $display("FAIL reset_no_done got done_seen=%b exp=0", saw_done); end
    run_op(3'b000, 32'd6, 32'hFFFF_FFF9, lat, bc);
    checks++;
    if (lat !== LAT || HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFD6) begin
      failures++; $display("FAIL after_reset_op got lat=%0d HI=%h LO=%h exp lat=%0d HI=ffffffff LO=ffffffd6", lat, HI, LO, LAT);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; MDOp = 3'b111; A = '0; B = '0;
    exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); reset = 1'b0;
    test_multu_timing();
    test_signed_directed();
    test_div_zero();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
